// File: rtl/ws2812b_pkg.sv
// Shared constants, state encoding and ns-to-cycles conversion for the
// WS2812B/SK6812 streaming LED driver.
package ws2812b_pkg;

  localparam int DEF_CLOCK_MHZ   = 64;
  localparam int DEF_T0H_NS      = 400;
  localparam int DEF_T1H_NS      = 800;
  localparam int DEF_PERIOD_NS   = 1250;
  localparam int DEF_RESET_NS    = 325000;
  localparam int DEF_UNDERRUN_NS = 5000;

  // FIFO entry: {latch, data[31:0]}
  localparam int ENTRY_W = 33;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RESET_LOW = 2'd3
  } state_t;

  // round(mhz * ns / 1000), evaluated in 64 bits, truncated to 16 bits
  function automatic logic [15:0] cycles_from_ns(input longint mhz, input longint ns);
    longint full;
    full = (mhz * ns + 64'sd500) / 64'sd1000;
    return full[15:0];
  endfunction

endpackage

// File: rtl/ws2812b_fifo.sv
// Synchronous show-ahead FIFO: o_rd_data always presents the oldest entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module ws2812b_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/ws2812b_stream.sv
// Buffered WS2812B/SK6812 transmitter: FIFO-fed bit engine that streams
// 24/32-bit pixels gap-free, latches frames and flags starvation.
module ws2812b_stream
  import ws2812b_pkg::*;
#(
  parameter int CLOCK_MHZ   = DEF_CLOCK_MHZ,
  parameter int FIFO_DEPTH  = 8,
  parameter int T0H_NS      = DEF_T0H_NS,
  parameter int T1H_NS      = DEF_T1H_NS,
  parameter int PERIOD_NS   = DEF_PERIOD_NS,
  parameter int RESET_NS    = DEF_RESET_NS,
  parameter int UNDERRUN_NS = DEF_UNDERRUN_NS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [31:0]                         s_data,
  input  logic                                s_latch,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic                                rgbw,
  output logic                                led,
  output logic                                busy,
  output logic                                underrun,
  input  logic                                clr_underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

  localparam logic [15:0] C_T0H      = cycles_from_ns(longint'(CLOCK_MHZ), longint'(T0H_NS));
  localparam logic [15:0] C_T1H      = cycles_from_ns(longint'(CLOCK_MHZ), longint'(T1H_NS));
  localparam logic [15:0] C_PERIOD   = cycles_from_ns(longint'(CLOCK_MHZ), longint'(PERIOD_NS));
  localparam logic [15:0] C_RESET    = cycles_from_ns(longint'(CLOCK_MHZ), longint'(RESET_NS));
  localparam logic [15:0] C_UNDERRUN = cycles_from_ns(longint'(CLOCK_MHZ), longint'(UNDERRUN_NS));

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_cnt;
  logic [31:0]         r_shift;
  logic [4:0]          r_bitcnt;
  logic                r_latch;
  logic                r_led;
  logic                r_rdy_en;
  logic                r_underrun;
  logic                w_push;
  logic                w_pop;
  logic                w_shift;
  logic                w_cnt_clr;
  logic                w_set_ur;
  logic                w_full;
  logic                w_empty;
  logic [ENTRY_W-1:0]  w_head;
  logic [15:0]         w_txh;

  assign s_ready  = r_rdy_en && !w_full;
  assign w_push   = s_valid && s_ready;
  assign busy     = (r_state != ST_IDLE) || !w_empty;
  assign led      = r_led;
  assign underrun = r_underrun;
  assign w_txh    = r_shift[31] ? C_T1H : C_T0H;

  ws2812b_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data ({s_latch, s_data}),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_set_ur    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_cnt == C_PERIOD - 16'd1) begin
          w_cnt_clr = 1'b1;
          if (r_bitcnt != 5'd0) w_shift = 1'b1;
          else if (r_latch)     w_state_nxt = ST_RESET_LOW;
          else if (!w_empty)    w_pop = 1'b1;  // next pixel starts with no gap
          else                  w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_SEND;
        end else if (r_cnt == C_UNDERRUN - 16'd1) begin
          w_set_ur    = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_RESET_LOW;
        end
      end
      ST_RESET_LOW: begin
        if (r_cnt == C_RESET - 16'd1) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = ST_RESET_LOW;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RESET_LOW;
      r_cnt      <= '0;
      r_led      <= 1'b0;
      r_rdy_en   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
      r_led    <= (r_state == ST_SEND) && (r_cnt < w_txh);
      r_rdy_en <= 1'b1;
      if (w_set_ur)          r_underrun <= 1'b1;
      else if (clr_underrun) r_underrun <= 1'b0;
    end
  end

  // Shift register is pure data; the FSM guarantees it is loaded before use.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift  <= rgbw ? w_head[31:0] : {w_head[23:0], 8'h00};
      r_bitcnt <= rgbw ? 5'd31 : 5'd23;
      r_latch  <= w_head[32];
    end else if (w_shift) begin
      r_shift  <= {r_shift[30:0], 1'b0};
      r_bitcnt <= r_bitcnt - 5'd1;
    end
  end

endmodule
